// File: rtl/int_arbiter_pkg.sv
// ============================================================================
// Module : int_arbiter_pkg
// Brief  : Shared constants and state encoding for the interrupt arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package int_arbiter_pkg;

   localparam int                 INT_BUS  = 8;
   localparam logic [INT_BUS-1:0] INT_NONE = '0;

   localparam logic [1:0] INTA_ENABLE  = 2'd0;
   localparam logic [1:0] INTA_PENDING = 2'd1;
   localparam logic [1:0] INTA_EDGE    = 2'd2;
   localparam logic [1:0] INTA_CLAIM   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVICE = 2'd1,
      ST_GAP     = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/int_sync_edge.sv
// ============================================================================
// Module : int_sync_edge
// Brief  : Multi-flop synchroniser for one interrupt line plus rising-edge detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module int_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_irq,
   output logic o_irq_s,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_irq_s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync    <= '0;
         r_irq_s_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_irq};
         r_irq_s_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_irq_s = r_sync[SYNC_STAGES-1];
   assign o_rise  = o_irq_s & ~r_irq_s_d;

endmodule

`default_nettype wire

// File: rtl/int_arbiter.sv
// ============================================================================
// Module : int_arbiter
// Brief  : Memory-mapped interrupt aggregator with fixed priority and claim/complete.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module int_arbiter
   import int_arbiter_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_i,
   input  logic               we_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        data_i,
   output logic [31:0]        data_o,
   output logic [INT_BUS-1:0] int_flag_o
);

   logic [NUM_SRC-1:0] w_irq_s;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_edge;
   logic [NUM_SRC-1:0] r_pend_edge;
   logic [NUM_SRC-1:0] w_pending;
   logic [NUM_SRC-1:0] w_req;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pend_nxt;
   logic [INT_BUS-1:0] w_id;
   logic [INT_BUS-1:0] r_cur_id;
   logic [INT_BUS-1:0] w_cur_nxt;
   logic [INT_BUS-1:0] r_flag;
   logic [INT_BUS-1:0] w_flag_nxt;
   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic               w_wr_en;
   logic               w_wr_pend;
   logic               w_wr_edge;
   logic               w_wr_claim;
   logic               w_complete;
   logic               w_unused;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      int_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .rst     (rst),
         .i_irq   (irq_i[k]),
         .o_irq_s (w_irq_s[k]),
         .o_rise  (w_rise[k])
      );
   end

   // Level sources track the synchronised line directly; edge sources use the latch.
   assign w_pending = (r_edge & r_pend_edge) | (~r_edge & w_irq_s);
   assign w_req     = w_pending & r_enable;

   assign w_wr_en    = we_i && (addr_i[3:2] == INTA_ENABLE);
   assign w_wr_pend  = we_i && (addr_i[3:2] == INTA_PENDING);
   assign w_wr_edge  = we_i && (addr_i[3:2] == INTA_EDGE);
   assign w_wr_claim = we_i && (addr_i[3:2] == INTA_CLAIM);
   assign w_complete = (r_state == ST_SERVICE) && w_wr_claim &&
                       (data_i[INT_BUS-1:0] == r_cur_id);

   always_comb begin
      w_clr = w_wr_pend ? data_i[NUM_SRC-1:0] : '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (w_complete && (r_cur_id == INT_BUS'(k + 1))) begin
            w_clr[k] = 1'b1;
         end
      end
   end

   // A new edge overrides any clear arriving in the same cycle.
   assign w_pend_nxt = r_edge & (w_rise | (r_pend_edge & ~w_clr));

   always_comb begin
      w_id = INT_NONE;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (w_req[k]) begin
            w_id = INT_BUS'(k + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enable    <= '0;
         r_edge      <= '0;
         r_pend_edge <= '0;
      end else begin
         r_pend_edge <= w_pend_nxt;
         if (w_wr_en) begin
            r_enable <= data_i[NUM_SRC-1:0];
         end
         if (w_wr_edge) begin
            r_edge <= data_i[NUM_SRC-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cur_id <= INT_NONE;
         r_flag   <= INT_NONE;
      end else begin
         r_state  <= w_state_nxt;
         r_cur_id <= w_cur_nxt;
         r_flag   <= w_flag_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur_id;
      w_flag_nxt  = r_flag;
      case (r_state)
         ST_IDLE: begin
            if (w_req != '0) begin
               w_state_nxt = ST_SERVICE;
               w_cur_nxt   = w_id;
               w_flag_nxt  = w_id;
            end
         end
         ST_SERVICE: begin
            if (w_complete) begin
               w_state_nxt = ST_GAP;
               w_cur_nxt   = INT_NONE;
               w_flag_nxt  = INT_NONE;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
            w_flag_nxt  = INT_NONE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cur_nxt   = INT_NONE;
            w_flag_nxt  = INT_NONE;
         end
      endcase
   end

   always_comb begin
      data_o = '0;
      case (addr_i[3:2])
         INTA_ENABLE:  data_o[NUM_SRC-1:0] = r_enable;
         INTA_PENDING: data_o[NUM_SRC-1:0] = w_pending;
         INTA_EDGE:    data_o[NUM_SRC-1:0] = r_edge;
         default:      data_o[INT_BUS-1:0] = r_cur_id;
      endcase
   end

   assign int_flag_o = r_flag;
   assign w_unused   = &{1'b0, addr_i[31:4], addr_i[1:0], data_i[31:INT_BUS]};

endmodule

`default_nettype wire
